cdc_hs_src: RTL

- Source-domain half of a toggle-handshake CDC data transfer.
- Accepts one data word per valid/ready transaction and latches it into a stable holding register.
- Signals the transfer by toggling a request level. That level is synchronized into the destination domain by a sync2_pgen.
- The acknowledge comes back as a one-cycle pulse from a second sync2_pgen clocked by this block's clock. The block issues no new request until that pulse arrives.

---
 rtl/cdc_hs_src.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cdc_hs_src.sv
// -----------------------------------------------------------------------------
// cdc_hs_src
// Source-domain half of a toggle-handshake clock-domain-crossing transfer.
// A word is accepted on a valid/ready handshake and latched into a holding
// register, and the request level is toggled on the same edge. The
// destination synchronizes the toggle. The acknowledge comes back as a
// one-cycle pulse already synchronized into this clock domain. No new word is
// accepted until that pulse has arrived.
//
// Handshake: a word transfers on a rising edge of c where i_valid and o_ready
// are both high. o_ready depends only on the state register. It never depends
// combinationally on i_valid or i_ack.
//
// Ports:
//   c          source-domain clock
//   rst_n      asynchronous reset, active-low
//   i_valid    upstream word valid
//   o_ready    block can accept a word (state is IDLE)
//   i_data     upstream data word
//   o_req      request toggle level, goes to the destination-side synchronizer
//   o_data     held data word, stable while a request is outstanding
//   i_ack      one-cycle acknowledge pulse (already synchronized)
//   o_done     one-cycle pulse: transfer acknowledged
//   o_timeout  acknowledge outstanding for at least TIMEOUT cycles
//   o_ack_err  sticky: acknowledge pulse received while idle
// -----------------------------------------------------------------------------
module cdc_hs_src #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic          c,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_req,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  output logic          o_done,
  output logic          o_timeout,
  output logic          o_ack_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  // The timer saturates at TIMEOUT. With TIMEOUT == 0 it stays at zero and
  // o_timeout can never be set, so synthesis removes both.
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t        state, state_nxt;
  logic          req_nxt;
  logic [DW-1:0] data_nxt;
  logic [15:0]   timer, timer_nxt;
  logic          done_nxt;
  logic          timeout_nxt;
  logic          ack_err_nxt;

  assign o_ready = (state == IDLE);

  always_comb begin
    state_nxt   = state;
    req_nxt     = o_req;
    data_nxt    = o_data;
    timer_nxt   = timer;
    done_nxt    = 1'b0;
    timeout_nxt = o_timeout;
    ack_err_nxt = o_ack_err;
    case (state)
      IDLE: begin
        // An ack with nothing outstanding is recorded, but the FSM ignores it.
        if (i_ack) ack_err_nxt = 1'b1;
        if (i_valid) begin
          // Data and toggle update on the same edge. o_data is therefore
          // stable long before the destination can see the toggle.
          data_nxt  = i_data;
          req_nxt   = ~o_req;
          timer_nxt = 16'd0;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_ack) begin
          // The ack wins over the timer update in the same cycle.
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          timeout_nxt = 1'b0;
          timer_nxt   = 16'd0;
        end else begin
          if (timer != TO_MAX) timer_nxt = timer + 16'd1;
          // A timeout only flags the condition. The transfer keeps waiting.
          if (TO_EN && (timer == TO_LAST)) timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      o_req     <= 1'b0;
      o_data    <= '0;
      timer     <= 16'd0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_ack_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_req     <= req_nxt;
      o_data    <= data_nxt;
      timer     <= timer_nxt;
      o_done    <= done_nxt;
      o_timeout <= timeout_nxt;
      o_ack_err <= ack_err_nxt;
    end
  end

endmodule
